// File: rtl/hood_mode_sequencer_if.sv
// Control/status bundle between the hood panel logic and the mode sequencer.
// The sequencer takes the slave side; the panel or bench drives the master side.
interface hood_mode_sequencer_if;
    logic       power_on;
    logic       menu_btn;
    logic       mode1_btn;
    logic       mode2_btn;
    logic       mode3_btn;
    logic       clean_btn;
    logic [2:0] mode_state;
    logic [7:0] countdown;
    logic       menu_armed;
    logic       hurricane_used;
    logic       clean_done;

    modport slave (
        input  power_on, menu_btn, mode1_btn, mode2_btn, mode3_btn, clean_btn,
        output mode_state, countdown, menu_armed, hurricane_used, clean_done
    );

    modport master (
        output power_on, menu_btn, mode1_btn, mode2_btn, mode3_btn, clean_btn,
        input  mode_state, countdown, menu_armed, hurricane_used, clean_done
    );
endinterface

// File: rtl/hood_mode_sequencer.sv
// Range-hood fan mode FSM: owns button arbitration, the one-second prescaler
// and every timed countdown (hurricane, stop delay, self-clean).
module hood_mode_sequencer #(
    parameter int TICKS_PER_SEC = 100000000,
    parameter int HURRICANE_SEC = 60,
    parameter int STOP_SEC      = 60,
    parameter int CLEAN_SEC     = 180
) (
    input  logic                  clk,
    input  logic                  rst,
    hood_mode_sequencer_if.slave  bus
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);

    // Button bit order: 0 menu, 1 mode1, 2 mode2, 3 mode3, 4 clean
    localparam int B_MENU  = 0;
    localparam int B_MODE1 = 1;
    localparam int B_MODE2 = 2;
    localparam int B_MODE3 = 3;
    localparam int B_CLEAN = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_L1,
        S_L2,
        S_L3,
        S_STOPPING,
        S_CLEAN
    } state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   presc_reg, presc_next;
    logic [7:0]      count_reg, count_next;
    logic            used_reg, used_next;
    logic            done_reg, done_next;
    logic [2:0]      mode_state_reg, mode_state_next;
    logic            armed_reg;

    logic [4:0]      btn_raw;
    logic [4:0]      btn_d_reg;
    logic [4:0]      rise;
    logic [4:0]      edge_reg;

    logic            take_menu, take_m1, take_m2, take_m3, take_clean;
    logic            timed, tick;

    assign btn_raw = {bus.clean_btn, bus.mode3_btn, bus.mode2_btn,
                      bus.mode1_btn, bus.menu_btn};

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_rise
            assign rise[gi] = btn_raw[gi] & ~btn_d_reg[gi];
        end
    endgenerate

    // Edges are registered, so a press acts one cycle after it is seen;
    // edges are dropped while power is off so no stale press survives power-up.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            btn_d_reg <= '0;
            edge_reg  <= '0;
        end else begin
            btn_d_reg <= btn_raw;
            edge_reg  <= bus.power_on ? rise : 5'b0;
        end
    end

    // Only the highest-priority edge is considered in a given cycle.
    assign take_menu  = edge_reg[B_MENU];
    assign take_m3    = edge_reg[B_MODE3] & ~edge_reg[B_MENU];
    assign take_m2    = edge_reg[B_MODE2] & ~edge_reg[B_MODE3] & ~edge_reg[B_MENU];
    assign take_m1    = edge_reg[B_MODE1] & ~edge_reg[B_MODE2] & ~edge_reg[B_MODE3]
                      & ~edge_reg[B_MENU];
    assign take_clean = edge_reg[B_CLEAN] & ~|edge_reg[3:0];

    assign timed = (state_reg == S_L3) || (state_reg == S_STOPPING) || (state_reg == S_CLEAN);
    assign tick  = timed && (presc_reg == PRESC_LAST);

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        presc_next = '0;
        used_next  = used_reg;
        done_next  = 1'b0;

        if (timed && !tick) begin
            presc_next = presc_reg + 1'b1;
        end

        if (!bus.power_on) begin
            state_next = S_IDLE;
            count_next = 8'd0;
            used_next  = 1'b0;
        end else if (tick && count_reg == 8'd1) begin
            // Expiry outranks any button taken in the same cycle.
            count_next = 8'd0;
            case (state_reg)
                S_L3:       state_next = S_L2;
                S_STOPPING: state_next = S_IDLE;
                S_CLEAN: begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end
                default:    state_next = S_IDLE;
            endcase
        end else begin
            if (tick) begin
                count_next = count_reg - 8'd1;
            end
            case (state_reg)
                S_IDLE: begin
                    if (take_menu) state_next = S_ARMED;
                end
                S_ARMED, S_L1, S_L2: begin
                    if (take_menu) begin
                        state_next = S_IDLE;
                    end else if (take_m3) begin
                        if (!used_reg) begin
                            state_next = S_L3;
                            count_next = 8'(HURRICANE_SEC);
                            used_next  = 1'b1;
                        end
                    end else if (take_m2) begin
                        state_next = S_L2;
                    end else if (take_m1) begin
                        state_next = S_L1;
                    end else if (take_clean && state_reg == S_ARMED) begin
                        state_next = S_CLEAN;
                        count_next = 8'(CLEAN_SEC);
                    end
                end
                S_L3: begin
                    if (take_menu) begin
                        state_next = S_STOPPING;
                        count_next = 8'(STOP_SEC);
                    end
                end
                default: ;
            endcase
        end

        // Restart the prescaler on every state change so each timed state
        // begins with a full second.
        if (state_next != state_reg) begin
            presc_next = '0;
        end
    end

    always_comb begin
        mode_state_next = 3'b000;
        case (state_next)
            S_L1:       mode_state_next = 3'b001;
            S_L2:       mode_state_next = 3'b010;
            S_L3:       mode_state_next = 3'b011;
            S_STOPPING: mode_state_next = 3'b010;
            S_CLEAN:    mode_state_next = 3'b100;
            default:    mode_state_next = 3'b000;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg      <= S_IDLE;
            presc_reg      <= '0;
            count_reg      <= 8'd0;
            used_reg       <= 1'b0;
            done_reg       <= 1'b0;
            mode_state_reg <= 3'b000;
            armed_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            presc_reg      <= presc_next;
            count_reg      <= count_next;
            used_reg       <= used_next;
            done_reg       <= done_next;
            mode_state_reg <= mode_state_next;
            armed_reg      <= (state_next == S_ARMED);
        end
    end

    assign bus.mode_state     = mode_state_reg;
    assign bus.countdown      = count_reg;
    assign bus.menu_armed     = armed_reg;
    assign bus.hurricane_used = used_reg;
    assign bus.clean_done     = done_reg;

endmodule

// File: tb/tb_hood_mode_sequencer.sv
// Directed bench for hood_mode_sequencer with short timers
// (4 ticks/s, hurricane 3 s, stop 2 s, clean 5 s).
module tb_hood_mode_sequencer;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;

    hood_mode_sequencer_if bus ();

    hood_mode_sequencer #(
        .TICKS_PER_SEC(4),
        .HURRICANE_SEC(3),
        .STOP_SEC     (2),
        .CLEAN_SEC    (5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Advance n clock edges and settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Button held high for exactly one edge; the state reacts on the next edge.
    task automatic press(input int which);
        case (which)
            0: bus.menu_btn  = 1'b1;
            1: bus.mode1_btn = 1'b1;
            2: bus.mode2_btn = 1'b1;
            3: bus.mode3_btn = 1'b1;
            default: bus.clean_btn = 1'b1;
        endcase
        step(1);
        bus.menu_btn  = 1'b0;
        bus.mode1_btn = 1'b0;
        bus.mode2_btn = 1'b0;
        bus.mode3_btn = 1'b0;
        bus.clean_btn = 1'b0;
        step(1);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst = 1'b0;
        bus.power_on  = 1'b0;
        bus.menu_btn  = 1'b0;
        bus.mode1_btn = 1'b0;
        bus.mode2_btn = 1'b0;
        bus.mode3_btn = 1'b0;
        bus.clean_btn = 1'b0;
        step(2);
        check_val("rst_mode",  32'(bus.mode_state), 0);
        check_val("rst_count", 32'(bus.countdown), 0);
        check_val("rst_armed", 32'(bus.menu_armed), 0);
        check_val("rst_used",  32'(bus.hurricane_used), 0);
        check_val("rst_done",  32'(bus.clean_done), 0);

        rst = 1'b1;
        bus.power_on = 1'b1;
        step(2);

        // menu -> ARMED, mode2 -> L2
        press(0);
        check_val("armed_after_menu", 32'(bus.menu_armed), 1);
        check_val("armed_mode",       32'(bus.mode_state), 0);
        press(2);
        check_val("l2_mode",  32'(bus.mode_state), 3'b010);
        check_val("l2_count", 32'(bus.countdown), 0);
        check_val("l2_armed", 32'(bus.menu_armed), 0);

        // back through IDLE to ARMED, then hurricane
        press(0);
        check_val("l2_menu_idle", 32'(bus.mode_state), 0);
        press(0);
        press(3);
        check_val("l3_mode",  32'(bus.mode_state), 3'b011);
        check_val("l3_count", 32'(bus.countdown), 3);
        check_val("l3_used",  32'(bus.hurricane_used), 1);
        step(3);
        check_val("l3_count_e3", 32'(bus.countdown), 3);
        step(1);
        check_val("l3_count_e4", 32'(bus.countdown), 2);
        step(7);
        check_val("l3_mode_e11",  32'(bus.mode_state), 3'b011);
        check_val("l3_count_e11", 32'(bus.countdown), 1);
        step(1);
        check_val("l3_expire_mode",  32'(bus.mode_state), 3'b010);
        check_val("l3_expire_count", 32'(bus.countdown), 0);

        // second hurricane in the same power cycle is refused
        press(3);
        check_val("l2_m3_refused", 32'(bus.mode_state), 3'b010);
        press(0);
        press(0);
        press(3);
        check_val("armed_m3_refused_armed", 32'(bus.menu_armed), 1);
        check_val("armed_m3_refused_mode",  32'(bus.mode_state), 0);
        press(0);

        // power cycle clears the hurricane lockout
        bus.power_on = 1'b0;
        step(1);
        check_val("poff_mode", 32'(bus.mode_state), 0);
        check_val("poff_used", 32'(bus.hurricane_used), 0);
        bus.power_on = 1'b1;
        step(1);
        press(0);
        press(3);
        check_val("l3_again_mode", 32'(bus.mode_state), 3'b011);
        check_val("l3_again_used", 32'(bus.hurricane_used), 1);

        // menu in L3 -> STOPPING (level 2 for 2 s), buttons ignored
        press(0);
        check_val("stop_mode",  32'(bus.mode_state), 3'b010);
        check_val("stop_count", 32'(bus.countdown), 2);
        press(1);
        check_val("stop_m1_ignored", 32'(bus.mode_state), 3'b010);
        step(5);
        check_val("stop_e7_mode",  32'(bus.mode_state), 3'b010);
        check_val("stop_e7_count", 32'(bus.countdown), 1);
        step(1);
        check_val("stop_expire_mode",  32'(bus.mode_state), 0);
        check_val("stop_expire_count", 32'(bus.countdown), 0);

        // self-clean for 5 s
        press(0);
        press(4);
        check_val("clean_mode",  32'(bus.mode_state), 3'b100);
        check_val("clean_count", 32'(bus.countdown), 5);
        step(4);
        check_val("clean_count_e4", 32'(bus.countdown), 4);
        step(15);
        check_val("clean_e19_mode",  32'(bus.mode_state), 3'b100);
        check_val("clean_e19_count", 32'(bus.countdown), 1);
        check_val("clean_e19_done",  32'(bus.clean_done), 0);
        step(1);
        check_val("clean_end_mode", 32'(bus.mode_state), 0);
        check_val("clean_end_done", 32'(bus.clean_done), 1);
        step(1);
        check_val("clean_done_drop", 32'(bus.clean_done), 0);

        // asynchronous reset mid-clean
        press(0);
        press(4);
        step(6);
        check_val("clean2_count", 32'(bus.countdown), 4);
        #2;
        rst = 1'b0;
        #1;
        check_val("arst_mode",  32'(bus.mode_state), 0);
        check_val("arst_count", 32'(bus.countdown), 0);
        check_val("arst_armed", 32'(bus.menu_armed), 0);
        check_val("arst_used",  32'(bus.hurricane_used), 0);
        check_val("arst_done",  32'(bus.clean_done), 0);
        rst = 1'b1;
        step(2);

        // simultaneous menu + mode1 from L2: menu wins
        press(0);
        press(2);
        check_val("l2b_mode", 32'(bus.mode_state), 3'b010);
        bus.menu_btn  = 1'b1;
        bus.mode1_btn = 1'b1;
        step(1);
        bus.menu_btn  = 1'b0;
        bus.mode1_btn = 1'b0;
        step(1);
        check_val("menu_beats_m1_mode",  32'(bus.mode_state), 0);
        check_val("menu_beats_m1_armed", 32'(bus.menu_armed), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
